// File: rtl/fpnew_pkg.sv
// FP format descriptors, class-info layout and generator types shared by the
// special-value generator and its pattern builder.
package fpnew_pkg;

    localparam int unsigned FP_FORMAT_BITS = 3;
    localparam int unsigned NUM_FP_FORMATS = 5;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        int unsigned exp_w;
        int unsigned man_w;
    } fp_encoding_t;

    localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
        '{exp_w: 8,  man_w: 23},
        '{exp_w: 11, man_w: 52},
        '{exp_w: 5,  man_w: 10},
        '{exp_w: 5,  man_w: 2},
        '{exp_w: 8,  man_w: 7}
    };

    typedef struct packed {
        logic normal;
        logic subnormal;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
        logic qnan;
        logic boxed;
    } classinfo_t;

    typedef enum logic [2:0] {
        SC_ZERO     = 3'd0,
        SC_SUB_MIN  = 3'd1,
        SC_SUB_MAX  = 3'd2,
        SC_NORM_MIN = 3'd3,
        SC_NORM_MAX = 3'd4,
        SC_INF      = 3'd5,
        SC_QNAN     = 3'd6,
        SC_SNAN     = 3'd7
    } special_class_e;

    typedef enum logic [0:0] {
        GEN_IDLE  = 1'b0,
        GEN_SWEEP = 1'b1
    } gen_state_e;

    // Unknown format codes yield zero-width fields; callers gate with fmt_err.
    function automatic int unsigned exp_bits(input logic [FP_FORMAT_BITS-1:0] fmt);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
            if (fmt == FP_FORMAT_BITS'(i)) r = FP_ENCODINGS[i].exp_w;
        end
        return r;
    endfunction

    function automatic int unsigned man_bits(input logic [FP_FORMAT_BITS-1:0] fmt);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
            if (fmt == FP_FORMAT_BITS'(i)) r = FP_ENCODINGS[i].man_w;
        end
        return r;
    endfunction

    function automatic int unsigned fp_width(input logic [FP_FORMAT_BITS-1:0] fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

// File: rtl/fpnew_special_pattern.sv
// Combinational builder: format/class/sign/box -> NaN-boxed bit pattern and
// the class-info word a classifier should report for it.
module fpnew_special_pattern
    import fpnew_pkg::*;
#(
    parameter int unsigned FLEN     = 64,
    parameter int unsigned FMT_BITS = 3
) (
    input  logic [FMT_BITS-1:0] fmt_i,
    input  logic [2:0]          class_i,
    input  logic                sign_i,
    input  logic                box_i,
    output logic [FLEN-1:0]     value_c,
    output logic [7:0]          info_c,
    output logic                fmt_err_c
);

    localparam int unsigned WW = 7;

    logic            fmt_ok;
    logic [WW-1:0]   exp_w;
    logic [WW-1:0]   man_w;
    logic [WW-1:0]   fmt_w;
    logic [FLEN-1:0] exp_ones;
    logic [FLEN-1:0] man_ones;
    logic [FLEN-1:0] exp_f;
    logic [FLEN-1:0] man_f;
    logic [FLEN-1:0] box_f;
    logic            sgn;
    classinfo_t      info;

    always_comb begin
        fmt_ok   = 32'(fmt_i) < NUM_FP_FORMATS;
        exp_w    = WW'(exp_bits(FP_FORMAT_BITS'(fmt_i)));
        man_w    = WW'(man_bits(FP_FORMAT_BITS'(fmt_i)));
        fmt_w    = WW'(fp_width(FP_FORMAT_BITS'(fmt_i)));
        exp_ones = (FLEN'(1) << exp_w) - FLEN'(1);
        man_ones = (FLEN'(1) << man_w) - FLEN'(1);
        sgn      = sign_i;
        exp_f    = '0;
        man_f    = '0;
        info     = '0;

        case (special_class_e'(class_i))
            SC_ZERO: begin
                info.zero = 1'b1;
            end
            SC_SUB_MIN: begin
                man_f          = FLEN'(1);
                info.subnormal = 1'b1;
            end
            SC_SUB_MAX: begin
                man_f          = man_ones;
                info.subnormal = 1'b1;
            end
            SC_NORM_MIN: begin
                exp_f       = FLEN'(1);
                info.normal = 1'b1;
            end
            SC_NORM_MAX: begin
                exp_f       = exp_ones - FLEN'(1);
                man_f       = man_ones;
                info.normal = 1'b1;
            end
            SC_INF: begin
                exp_f    = exp_ones;
                info.inf = 1'b1;
            end
            // Canonical quiet NaN is always positive.
            SC_QNAN: begin
                sgn       = 1'b0;
                exp_f     = exp_ones;
                man_f     = FLEN'(1) << (man_w - WW'(1));
                info.nan  = 1'b1;
                info.qnan = 1'b1;
            end
            SC_SNAN: begin
                exp_f     = exp_ones;
                man_f     = FLEN'(1);
                info.nan  = 1'b1;
                info.snan = 1'b1;
            end
        endcase

        if (box_i && (32'(fmt_w) < FLEN)) box_f = ~FLEN'(0) << fmt_w;
        else                              box_f = '0;

        info.boxed = box_i;
        value_c    = box_f | (FLEN'(sgn) << (fmt_w - WW'(1))) | (exp_f << man_w) | man_f;
        // An unboxed narrow value reads back as the canonical NaN.
        info_c     = box_i ? 8'(info) : 8'b0000_1010;
        fmt_err_c  = !fmt_ok;

        if (!fmt_ok) begin
            value_c = '0;
            info_c  = '0;
        end
    end

endmodule

// File: rtl/fpnew_special_gen.sv
// Special-value generator: request port or 16-item self-test sweep feeds one
// pattern builder, followed by a single valid/ready output register.
module fpnew_special_gen
    import fpnew_pkg::*;
#(
    parameter int unsigned FLEN     = 64,
    parameter int unsigned FMT_BITS = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [FMT_BITS-1:0] fmt_i,
    input  logic [2:0]          class_i,
    input  logic                sign_i,
    input  logic                box_i,
    input  logic                sweep_start_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [FLEN-1:0]     value_o,
    output logic [7:0]          info_o,
    output logic                fmt_err_o,
    output logic                sweep_busy_o,
    output logic                sweep_done_o
);

    localparam int unsigned IDX_W     = 5;
    localparam int unsigned SWEEP_LEN = 16;

    gen_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FMT_BITS-1:0] sweep_fmt_q, sweep_fmt_d;
    logic                out_valid_q, out_valid_d;
    logic [FLEN-1:0]     value_q, value_d;
    logic [7:0]          info_q, info_d;
    logic                fmt_err_q, fmt_err_d;

    logic                in_sweep;
    logic                stage_free;
    logic                sweep_last;
    logic                load;
    logic [FMT_BITS-1:0] pat_fmt;
    logic [2:0]          pat_class;
    logic                pat_sign;
    logic                pat_box;
    logic [FLEN-1:0]     pat_value;
    logic [7:0]          pat_info;
    logic                pat_err;

    assign in_sweep   = (state_q == GEN_SWEEP);
    assign stage_free = !out_valid_q || out_ready_i;
    // idx has advanced past the final item once all 16 have been loaded.
    assign sweep_last = (idx_q == IDX_W'(SWEEP_LEN));

    // Sweep items are always boxed and walk class then sign.
    always_comb begin
        pat_fmt   = fmt_i;
        pat_class = class_i;
        pat_sign  = sign_i;
        pat_box   = box_i;
        if (in_sweep) begin
            pat_fmt   = sweep_fmt_q;
            pat_class = idx_q[2:0];
            pat_sign  = idx_q[3];
            pat_box   = 1'b1;
        end
    end

    fpnew_special_pattern #(
        .FLEN     (FLEN),
        .FMT_BITS (FMT_BITS)
    ) u_pattern (
        .fmt_i     (pat_fmt),
        .class_i   (pat_class),
        .sign_i    (pat_sign),
        .box_i     (pat_box),
        .value_c   (pat_value),
        .info_c    (pat_info),
        .fmt_err_c (pat_err)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sweep_fmt_d = sweep_fmt_q;
        out_valid_d = out_valid_q;
        value_d     = value_q;
        info_d      = info_q;
        fmt_err_d   = fmt_err_q;
        load        = 1'b0;

        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

        case (state_q)
            GEN_IDLE: begin
                if (sweep_start_i) begin
                    state_d     = GEN_SWEEP;
                    sweep_fmt_d = fmt_i;
                    idx_d       = '0;
                end else if (in_valid_i && stage_free) begin
                    load = 1'b1;
                end
            end
            GEN_SWEEP: begin
                if (!sweep_last && stage_free) begin
                    load  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                end else if (sweep_last && out_valid_q && out_ready_i) begin
                    state_d = GEN_IDLE;
                end
            end
            default: state_d = GEN_IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            value_d     = pat_value;
            info_d      = pat_info;
            fmt_err_d   = pat_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= GEN_IDLE;
            idx_q       <= '0;
            sweep_fmt_q <= '0;
            out_valid_q <= 1'b0;
            value_q     <= '0;
            info_q      <= '0;
            fmt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sweep_fmt_q <= sweep_fmt_d;
            out_valid_q <= out_valid_d;
            value_q     <= value_d;
            info_q      <= info_d;
            fmt_err_q   <= fmt_err_d;
        end
    end

    assign in_ready_o   = !in_sweep && !sweep_start_i && stage_free;
    assign out_valid_o  = out_valid_q;
    assign value_o      = value_q;
    assign info_o       = info_q;
    assign fmt_err_o    = fmt_err_q;
    assign sweep_busy_o = in_sweep;
    assign sweep_done_o = !rst_i && in_sweep && sweep_last && out_valid_q && out_ready_i;

endmodule

// File: tb/tb_fpnew_special_gen.sv
// Directed + randomized bench for fpnew_special_gen with a scoreboard fed by a
// format-table reference model and a value-decoding classifier.
module tb_fpnew_special_gen;

    typedef struct packed {
        logic [63:0] v;
        logic [7:0]  info;
        logic        err;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  fmt_i;
    logic [2:0]  class_i;
    logic        sign_i;
    logic        box_i;
    logic        sweep_start_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] value_o;
    logic [7:0]  info_o;
    logic        fmt_err_o;
    logic        sweep_busy_o;
    logic        sweep_done_o;

    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   pulses   = 0;
    logic acc;
    logic s_in_ready;
    exp_t sb[$];

    always #5 clk = ~clk;

    fpnew_special_gen #(.FLEN(64), .FMT_BITS(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .fmt_i         (fmt_i),
        .class_i       (class_i),
        .sign_i        (sign_i),
        .box_i         (box_i),
        .sweep_start_i (sweep_start_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .value_o       (value_o),
        .info_o        (info_o),
        .fmt_err_o     (fmt_err_o),
        .sweep_busy_o  (sweep_busy_o),
        .sweep_done_o  (sweep_done_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reads a pattern back the way a classifier would: decode fields, then box bits.
    function automatic logic [7:0] classify(input logic [63:0] v, input int e, input int m);
        logic [63:0] emax, mones, ef, mf;
        logic [7:0]  r;
        int          w;
        w     = 1 + e + m;
        emax  = (64'd1 << e) - 64'd1;
        mones = (64'd1 << m) - 64'd1;
        ef    = (v >> m) & emax;
        mf    = v & mones;
        r     = 8'h00;
        if (ef == 64'd0)       r = (mf == 64'd0) ? 8'h20 : 8'h40;
        else if (ef == emax) begin
            if (mf == 64'd0)                 r = 8'h10;
            else if (((mf >> (m - 1)) & 64'd1) != 64'd0) r = 8'h0A;
            else                             r = 8'h0C;
        end else                             r = 8'h80;
        if (w == 64 || (v >> w) == (~64'd0 >> w)) r = r | 8'h01;
        return r;
    endfunction

    function automatic exp_t model(input logic [2:0] fmt, input logic [2:0] cls,
                                   input logic s, input logic b, input logic last);
        exp_t        r;
        int          e, m, w;
        logic [63:0] emax, mones, ef, mf, v;
        logic        sg;
        r      = '0;
        r.last = last;
        e      = 0;
        m      = 0;
        case (fmt)
            3'd0: begin e = 8;  m = 23; end
            3'd1: begin e = 11; m = 52; end
            3'd2: begin e = 5;  m = 10; end
            3'd3: begin e = 5;  m = 2;  end
            3'd4: begin e = 8;  m = 7;  end
            default: begin r.err = 1'b1; return r; end
        endcase
        w     = 1 + e + m;
        emax  = (64'd1 << e) - 64'd1;
        mones = (64'd1 << m) - 64'd1;
        sg    = s;
        ef    = 64'd0;
        mf    = 64'd0;
        case (cls)
            3'd1: mf = 64'd1;
            3'd2: mf = mones;
            3'd3: ef = 64'd1;
            3'd4: begin ef = emax - 64'd1; mf = mones; end
            3'd5: ef = emax;
            3'd6: begin sg = 1'b0; ef = emax; mf = 64'd1 << (m - 1); end
            3'd7: begin ef = emax; mf = 64'd1; end
            default: ;
        endcase
        v = ({63'd0, sg} << (w - 1)) | (ef << m) | mf;
        if (b && w < 64) v = v | (~64'd0 << w);
        r.v    = v;
        r.info = b ? classify(v, e, m) : 8'h0A;
        return r;
    endfunction

    // One clock: sample handshakes mid-cycle, score them, advance to posedge+1.
    task automatic cycle();
        exp_t e;
        logic con;
        #4;
        s_in_ready = in_ready_o;
        acc        = in_valid_i && in_ready_o;
        con        = out_valid_o && out_ready_i;
        if (con) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                chk("value", value_o, e.v);
                chk("info", 64'(info_o), 64'(e.info));
                chk("fmt_err", 64'(fmt_err_o), 64'(e.err));
                chk("sweep_done_at_last", 64'(sweep_done_o), 64'(e.last));
            end
        end else begin
            chk("sweep_done_idle", 64'(sweep_done_o), 64'd0);
        end
        if (sweep_done_o === 1'b1) pulses++;
        if (acc) begin
            sb.push_back(model(fmt_i, class_i, sign_i, box_i, 1'b0));
            pushed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] f, input logic [2:0] c, input logic s, input logic b);
        int n;
        fmt_i = f; class_i = c; sign_i = s; box_i = b;
        in_valid_i = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!acc && n < 50);
        chk("req_accept", 64'(acc), 64'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 60) begin cycle(); n++; end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold;
        int          n;
        int          base;

        rst_i = 1'b1; in_valid_i = 1'b0; sweep_start_i = 1'b0; out_ready_i = 1'b0;
        fmt_i = 3'd0; class_i = 3'd0; sign_i = 1'b0; box_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_value", value_o, 64'd0);
        chk("rst_info", 64'(info_o), 64'd0);
        chk("rst_fmt_err", 64'(fmt_err_o), 64'd0);
        chk("rst_busy", 64'(sweep_busy_o), 64'd0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;

        // Directed special values, latency one.
        req(3'd0, 3'd4, 1'b1, 1'b1);
        chk("fp32_max_valid", 64'(out_valid_o), 64'd1);
        chk("fp32_max_value", value_o, 64'hFFFFFFFF_FF7FFFFF);
        chk("fp32_max_info", 64'(info_o), 64'h81);
        cycle();
        req(3'd2, 3'd6, 1'b1, 1'b1);
        chk("fp16_qnan_value", value_o, 64'hFFFFFFFF_FFFF7E00);
        chk("fp16_qnan_info", 64'(info_o), 64'h0B);
        cycle();
        req(3'd1, 3'd5, 1'b0, 1'b1);
        chk("fp64_inf_value", value_o, 64'h7FF00000_00000000);
        chk("fp64_inf_info", 64'(info_o), 64'h11);
        cycle();
        req(3'd3, 3'd1, 1'b0, 1'b0);
        chk("fp8_sub_value", value_o, 64'h00000000_00000001);
        chk("fp8_sub_info", 64'(info_o), 64'h0A);
        cycle();
        req(3'd6, 3'd3, 1'b1, 1'b1);
        chk("bad_fmt_value", value_o, 64'd0);
        chk("bad_fmt_info", 64'(info_o), 64'd0);
        chk("bad_fmt_err", 64'(fmt_err_o), 64'd1);
        cycle();
        drain();

        // Backpressure: output held, input stalled, then back-to-back.
        req(3'd0, 3'd0, 1'b0, 1'b1);
        out_ready_i = 1'b0;
        fmt_i = 3'd4; class_i = 3'd7; sign_i = 1'b1; box_i = 1'b1; in_valid_i = 1'b1;
        hold = value_o;
        repeat (3) begin
            cycle();
            chk("bp_in_ready", 64'(s_in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_stable", value_o, hold);
        end
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fmt_i = 3'(k); class_i = 3'(k + 2); sign_i = k[0];
            cycle();
            chk("b2b_accept", 64'(acc), 64'd1);
        end
        drain();
        chk("no_loss_dup", 64'(popped), 64'(pushed));

        // Randomized request stream with random backpressure.
        for (int k = 0; k < 150; k++) begin
            fmt_i = 3'($urandom_range(0, 7)); class_i = 3'($urandom);
            sign_i = 1'($urandom); box_i = 1'($urandom);
            in_valid_i = 1'b1;
            n = 0;
            do begin
                out_ready_i = ($urandom_range(0, 3) != 0);
                cycle();
                n++;
            end while (!acc && n < 64);
            chk("rand_accept", 64'(acc), 64'd1);
        end
        drain();

        // Full FP16ALT sweep with random backpressure and ignored inputs.
        base = pulses;
        fmt_i = 3'd4; sweep_start_i = 1'b1; in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        cycle();
        chk("start_blocks_req", 64'(s_in_ready), 64'd0);
        sweep_start_i = 1'b0;
        for (int i = 0; i < 16; i++)
            sb.push_back(model(3'd4, 3'(i), i[3], 1'b1, (i == 15)));
        chk("sweep_busy", 64'(sweep_busy_o), 64'd1);
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            out_ready_i   = 1'($urandom);
            sweep_start_i = 1'($urandom);
            fmt_i         = 3'($urandom);
            in_valid_i    = 1'($urandom);
            cycle();
            chk("sweep_in_ready", 64'(s_in_ready), 64'd0);
            n++;
        end
        in_valid_i = 1'b0; sweep_start_i = 1'b0;
        chk("sweep_complete", 64'(sb.size()), 64'd0);
        chk("sweep_done_once", 64'(pulses - base), 64'd1);
        chk("sweep_idle_after", 64'(sweep_busy_o), 64'd0);

        // Reset while item 7 is held in the output register.
        base = pulses;
        fmt_i = 3'd0; sweep_start_i = 1'b1; out_ready_i = 1'b1;
        cycle();
        sweep_start_i = 1'b0;
        for (int i = 0; i < 16; i++)
            sb.push_back(model(3'd0, 3'(i), i[3], 1'b1, (i == 15)));
        n = popped;
        for (int k = 0; k < 40 && (popped - n) < 7; k++) cycle();
        chk("pre_reset_items", 64'(popped - n), 64'd7);
        out_ready_i = 1'b0;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_busy", 64'(sweep_busy_o), 64'd0);
        chk("mid_rst_value", value_o, 64'd0);
        chk("mid_rst_info", 64'(info_o), 64'd0);
        sb.delete();
        out_ready_i = 1'b1;
        repeat (20) cycle();
        chk("no_done_after_rst", 64'(pulses - base), 64'd0);
        req(3'd1, 3'd7, 1'b1, 1'b1);
        chk("post_rst_value", value_o, 64'hFFF00000_00000001);
        chk("post_rst_info", 64'(info_o), 64'h0D);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
